// File: rtl/bit_serial_pkg.sv
// Shared types and constants for the bit-serial adder.
package bit_serial_pkg;

    // Controller states of the bit-serial adder
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_fa_slice.sv
// One-bit full-adder cell: parity sum and majority carry.
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    // Pure combinational sum/carry
    always_comb begin
        s  = a ^ b ^ cin;
        co = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands one bit per clock, LSB first,
// using a single fa_slice, a carry flop and operand shift registers.
// Optional macro BIT_SERIAL_ADDER_OVF_EN adds a signed-overflow output (ovf).
module bit_serial_adder
    import bit_serial_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BIT_SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-2:0]   sum_sh;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               s_bit;
    logic               c_next;
    logic               last_bit;

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    fa_slice u_fa (
        .a   (a_sh[0]),
        .b   (b_sh[0]),
        .cin (carry),
        .s   (s_bit),
        .co  (c_next)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture, serial add, result commit.
    // The result is committed on the last RUN edge (including the final
    // sum bit straight from the slice) so sum/cout are valid while done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef BIT_SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    sum_sh <= (WIDTH-1)'({s_bit, sum_sh} >> 1);
                    carry  <= c_next;
                    if (last_bit) begin
                        cnt  <= '0;
                        sum  <= {s_bit, sum_sh};
                        cout <= c_next;
`ifdef BIT_SERIAL_ADDER_OVF_EN
                        // carry still holds the carry into the MSB here
                        ovf  <= carry ^ c_next;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench for bit_serial_adder (WIDTH=8), scoreboard based.
module tb_bit_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef BIT_SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int done_count = 0;
    int prev_done_cyc = 0;
    bit have_prev = 1'b0;
    bit check_interval = 1'b0;

    // expected {ovf, cout, sum}
    logic [W+1:0] exp_q[$];

    bit_serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef BIT_SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: plain integer arithmetic from the operand values
    function automatic logic [W+1:0] model(logic [W-1:0] x, logic [W-1:0] y, logic c);
        int unsigned u;
        int s;
        logic v;
        u = int'(x) + int'(y) + int'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        v = (s > 127) || (s < -128);
        return {v, u[W:0]};
    endfunction

    // Monitor: pop and compare on every done pulse
    always @(negedge clk) begin
        logic [W+1:0] e;
        cyc++;
        if (!rst && done) begin
            done_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("cout_sum", {cout, sum}, e[W:0]);
`ifdef BIT_SERIAL_ADDER_OVF_EN
                chk("ovf", ovf, e[W+1]);
`endif
            end
            if (check_interval && have_prev)
                chk("done_interval", cyc - prev_done_cyc, W + 2);
            prev_done_cyc = cyc;
            have_prev = 1'b1;
        end
    end

    // Issue one add at a negedge in IDLE; checks busy/done timing; returns
    // at the negedge where the DUT is back in IDLE.
    task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
        a = x; b = y; cin = c; start = 1'b1;
        exp_q.push_back(model(x, y, c));
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; cin = $urandom;
        for (int i = 0; i < W; i++) begin
            chk("busy_run", {busy, done}, 2'b10);
            @(negedge clk);
        end
        chk("done_latency", {busy, done}, 2'b01);
        @(negedge clk);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
`ifdef BIT_SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 0);
`endif
        rst = 1'b0;
        d0 = done_count;
        repeat (10) @(negedge clk);
        chk("idle_no_done", done_count - d0, 0);

        // Directed cases
        do_add(8'h3C, 8'h05, 1'b0);
        chk("basic_sum_hold", sum, 8'h41);
        do_add(8'hFF, 8'h01, 1'b1);
        do_add(8'h7F, 8'h01, 1'b0);
        do_add(8'hFF, 8'h01, 1'b0);
        do_add(8'h00, 8'h00, 1'b0);
        do_add(8'hFF, 8'hFF, 1'b1);

        // Start while busy is ignored
        d0 = done_count;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("busy_restart_one_done", done_count - d0, 1);
        chk("busy_restart_sum", sum, 8'h30);

        // Reset mid-operation discards the partial result
        d0 = done_count;
        a = 8'h55; b = 8'h22; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        repeat (12) @(negedge clk);
        chk("midrst_no_done", done_count - d0, 0);
        do_add(8'h01, 8'h01, 1'b0);
        chk("after_rst_sum", sum, 8'h02);

        // Back-to-back random
        have_prev = 1'b0;
        check_interval = 1'b1;
        d0 = done_count;
        for (int n = 0; n < 1000; n++)
            do_add(W'($urandom), W'($urandom), 1'($urandom));
        check_interval = 1'b0;
        chk("b2b_done_count", done_count - d0, 1000);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
